split_11_gen: RTL

//  Solution generator for the split_11 constraint set. Draws pseudo-random candidates for
//  var_140[3:0] and var_11[11:0] and filters them with the same constraint predicate.

---
 rtl/split_11_pkg.sv | 41 ++++
 rtl/split_11_check.sv | 23 ++
 rtl/split_11_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/split_11_pkg.sv
// -----------------------------------------------------------------------------
// split_11_pkg
// Shared types, constants and the constraint predicate for the split_11
// solution generator.
//   state_t : generator FSM states (IDLE, DRAW, CHECK, HOLD)
//   C_ADD   : offset added to var_11 in the cc term
//   C_DIV   : divisor applied to the wrapped var_140 complement in the ca term
//   C_SHIFT : right shift applied to the cc sum
//   sat_f   : full predicate ca & cb & cc on one candidate
// -----------------------------------------------------------------------------
package split_11_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [15:0] C_ADD   = 16'hBA9;
    localparam logic [3:0]  C_DIV   = 4'h5;
    localparam int          C_SHIFT = 4;

    // The predicate is evaluated exactly as the constraint set writes it, with
    // every intermediate held at 16 bits, so that the hardware matches the
    // solver's arithmetic bit for bit rather than a hand-simplified range test.
    function automatic logic sat_f(input logic [3:0] v140, input logic [11:0] v11);
        logic [15:0] diff;
        logic [15:0] sum;
        logic        ca;
        logic        cb;
        logic        cc;
        diff = (16'd16 - {12'd0, v140}) & 16'h000F;
        ca   = (diff / {12'd0, C_DIV}) != 16'd0;
        cb   = (v140 != 4'd0) && (v11 != 12'd0);
        sum  = {4'd0, v11} + C_ADD;
        cc   = (sum >> C_SHIFT) != 16'd0;
        return ca & cb & cc;
    endfunction

endpackage

// File: rtl/split_11_check.sv
// -----------------------------------------------------------------------------
// split_11_check
// Purely combinational constraint checker for one split_11 candidate.
// Ports:
//   var_140 in  4   candidate field
//   var_11  in  12  candidate field
//   sat     out 1   candidate satisfies every constraint
// -----------------------------------------------------------------------------
module split_11_check
    import split_11_pkg::*;
(
    input  logic [3:0]  var_140,
    input  logic [11:0] var_11,
    output logic        sat
);

    // Thin wrapper so the predicate lives in exactly one place (the package)
    // while still appearing as its own block in the hierarchy.
    always_comb begin
        sat = sat_f(var_140, var_11);
    end

endmodule

// File: rtl/split_11_gen.sv
// -----------------------------------------------------------------------------
// split_11_gen
// Solution generator for the split_11 constraint set. A Galois LFSR supplies
// candidates for var_140/var_11; each candidate is filtered by split_11_check
// and one satisfying assignment (or the last candidate, flagged with out_fail,
// once MAX_TRIES draws are exhausted) is returned per request.
//
// Ports:
//   clk          in   1       clock
//   rst          in   1       synchronous reset, active-high
//   seed_load    in   1       load seed (only honoured in IDLE)
//   seed         in   LFSR_W  seed value, 0 is replaced by 1
//   req_valid    in   1       request one solution
//   req_ready    out  1       request can be taken (IDLE, no seed load)
//   out_valid    out  1       result available
//   out_ready    in   1       consumer accepts result
//   out_fail     out  1       result is the last candidate after giving up
//   var_140      out  4       solution field
//   var_11       out  12      solution field
//   busy         out  1       search or hand-off in progress
//   stat_accepts out  32      (SPLIT11_GEN_STATS_EN only) successful hand-offs
//   stat_rejects out  32      (SPLIT11_GEN_STATS_EN only) rejected candidates
//
// Optional feature macro: SPLIT11_GEN_STATS_EN adds the saturating statistics
// counters and their ports; without it the block has no counters at all.
// -----------------------------------------------------------------------------
module split_11_gen
    import split_11_pkg::*;
#(
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] LFSR_MASK = 32'h80200003,
    parameter int                MAX_TRIES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_fail,
    output logic [3:0]        var_140,
    output logic [11:0]       var_11,
    output logic              busy
`ifdef SPLIT11_GEN_STATS_EN
    ,
    output logic [31:0]       stat_accepts,
    output logic [31:0]       stat_rejects
`endif
);

    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]   lfsr_next;
    logic [TRIES_W-1:0]  tries_q, tries_d;
    logic [3:0]          var_140_q, var_140_d;
    logic [11:0]         var_11_q, var_11_d;
    logic                out_fail_q, out_fail_d;
    logic                sat;

    // The candidate registers double as the output fields: they are loaded in
    // DRAW, judged in CHECK and simply held through HOLD.
    split_11_check u_check (
        .var_140 (var_140_q),
        .var_11  (var_11_q),
        .sat     (sat)
    );

    // One Galois step, shifting right and folding the taps in when the bit
    // falling off the bottom is set.
    always_comb begin
        lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    end

    // Next-state logic. A seed load in IDLE wins over a request in the same
    // cycle, which is why req_ready drops while seed_load is high: the
    // handshake never completes unless the request is actually taken.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        tries_d    = tries_q;
        var_140_d  = var_140_q;
        var_11_d   = var_11_q;
        out_fail_d = out_fail_q;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
                end else if (req_valid) begin
                    tries_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                lfsr_d    = lfsr_next;
                var_140_d = lfsr_next[3:0];
                var_11_d  = lfsr_next[15:4];
                state_d   = CHECK;
            end
            CHECK: begin
                if (sat) begin
                    out_fail_d = 1'b0;
                    state_d    = HOLD;
                end else if (tries_q == LAST_TRY) begin
                    out_fail_d = 1'b1;
                    state_d    = HOLD;
                end else begin
                    tries_d = tries_q + TRIES_W'(1);
                    state_d = DRAW;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset also aborts any search in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_W'(1);
            tries_q    <= '0;
            var_140_q  <= '0;
            var_11_q   <= '0;
            out_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            tries_q    <= tries_d;
            var_140_q  <= var_140_d;
            var_11_q   <= var_11_d;
            out_fail_q <= out_fail_d;
        end
    end

    // Handshake and status outputs decode straight from the state register.
    always_comb begin
        req_ready = (state_q == IDLE) && !seed_load;
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        out_fail  = out_fail_q;
        var_140   = var_140_q;
        var_11    = var_11_q;
    end

`ifdef SPLIT11_GEN_STATS_EN
    logic [31:0] stat_accepts_q, stat_accepts_d;
    logic [31:0] stat_rejects_q, stat_rejects_d;

    // Saturating event counters: accepts count successful hand-offs only,
    // rejects count every candidate that failed the predicate.
    always_comb begin
        stat_accepts_d = stat_accepts_q;
        stat_rejects_d = stat_rejects_q;
        if ((state_q == HOLD) && out_ready && !out_fail_q && (stat_accepts_q != 32'hFFFF_FFFF)) begin
            stat_accepts_d = stat_accepts_q + 32'd1;
        end
        if ((state_q == CHECK) && !sat && (stat_rejects_q != 32'hFFFF_FFFF)) begin
            stat_rejects_d = stat_rejects_q + 32'd1;
        end
    end

    // Counter registers, cleared with the rest of the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accepts_q <= '0;
            stat_rejects_q <= '0;
        end else begin
            stat_accepts_q <= stat_accepts_d;
            stat_rejects_q <= stat_rejects_d;
        end
    end

    assign stat_accepts = stat_accepts_q;
    assign stat_rejects = stat_rejects_q;
`endif

endmodule
